// File: rtl/road_steer_ctrl_pkg.sv
// Shared road game package: FSM states, steering decisions and default limits.
// Imported by the steering controller and its testbench.
package road_steer_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRAP1 = 2'd2,
        S_WRAP2 = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        D_NONE  = 2'd0,
        D_LEFT  = 2'd1,
        D_RIGHT = 2'd2,
        D_WRAP  = 2'd3
    } dec_e;

    localparam int unsigned STEP_FRAMES_DEF = 2;
    localparam logic [15:0] LEFT_LIMIT_DEF  = 16'd8;
    localparam logic [15:0] RIGHT_LIMIT_DEF = 16'd560;

    // A lone button at its limit wraps the road instead of stepping.
    function automatic dec_e decide(
        input logic        bl,
        input logic        br,
        input logic [15:0] pos,
        input logic [15:0] lo,
        input logic [15:0] hi
    );
        dec_e d;
        d = D_NONE;
        if (bl && !br) begin
            d = (pos > lo) ? D_LEFT : D_WRAP;
        end else if (br && !bl) begin
            d = (pos < hi) ? D_RIGHT : D_WRAP;
        end
        return d;
    endfunction

endpackage

// File: rtl/road_steer_ctrl_sync2.sv
// Two-flop synchronizer for one asynchronous button input.
// Synchronous active-high reset clears both stages.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/road_steer_ctrl.sv
// Road steering controller: turns synchronized buttons into per-frame
// left/right/rollover pulses for the road horizontal counter.
module road_steer_ctrl
    import road_steer_ctrl_pkg::*;
#(
    parameter int unsigned STEP_FRAMES = STEP_FRAMES_DEF,
    parameter logic [15:0] LEFT_LIMIT  = LEFT_LIMIT_DEF,
    parameter logic [15:0] RIGHT_LIMIT = RIGHT_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame,
    input  logic        go,
    input  logic        btnL,
    input  logic        btnR,
    input  logic [15:0] road_h_address,
    output logic        L,
    output logic        R,
    output logic        rollover,
    output logic        active
);

    localparam logic [7:0] LAST_FRAME = 8'(STEP_FRAMES - 1);

    logic   btn_l_s;
    logic   btn_r_s;
    dec_e   dec_d;
    state_e state_q;
    logic [7:0] fcnt_q;
    logic   l_q;
    logic   r_q;
    logic   ro_q;
    logic   act_q;

    sync2 u_sync_l (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (btnL),
        .q_o   (btn_l_s)
    );

    sync2 u_sync_r (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (btnR),
        .q_o   (btn_r_s)
    );

    always_comb begin
        dec_d = decide(btn_l_s, btn_r_s, road_h_address,
                       LEFT_LIMIT, RIGHT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            fcnt_q  <= 8'd0;
            l_q     <= 1'b0;
            r_q     <= 1'b0;
            ro_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            l_q  <= 1'b0;
            r_q  <= 1'b0;
            ro_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    fcnt_q <= 8'd0;
                    if (go) begin
                        state_q <= S_RUN;
                        act_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (frame) begin
                        if (fcnt_q == LAST_FRAME) begin
                            fcnt_q <= 8'd0;
                            case (dec_d)
                                D_LEFT:  l_q <= 1'b1;
                                D_RIGHT: r_q <= 1'b1;
                                D_WRAP: begin
                                    ro_q    <= 1'b1;
                                    state_q <= S_WRAP1;
                                end
                                default: ;
                            endcase
                        end else begin
                            fcnt_q <= fcnt_q + 8'd1;
                        end
                    end
                end
                // Give the road counter one quiet clock to settle its load.
                S_WRAP1: state_q <= S_WRAP2;
                S_WRAP2: begin
                    state_q <= S_RUN;
                    fcnt_q  <= 8'd0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign L        = l_q;
    assign R        = r_q;
    assign rollover = ro_q;
    assign active   = act_q;

endmodule

// File: tb/tb_road_steer_ctrl.sv
// Self-checking bench for road_steer_ctrl: directed scenarios plus
// randomized traffic compared against a frame-level reference model.
module tb_road_steer_ctrl;

    localparam int          STEP = 2;
    localparam logic [15:0] LL   = 16'd8;
    localparam logic [15:0] RL   = 16'd560;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_W1   = 2;
    localparam int M_W2   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame = 1'b0;
    logic        go = 1'b0;
    logic        btnL = 1'b0;
    logic        btnR = 1'b0;
    logic [15:0] road = 16'd300;
    logic        L, R, rollover, active;

    int n_tests = 0;
    int n_fail  = 0;

    int   m_mode;
    int   m_frames;
    bit   hl[$];
    bit   hr[$];
    logic [3:0] exp_v;

    road_steer_ctrl #(
        .STEP_FRAMES (STEP),
        .LEFT_LIMIT  (LL),
        .RIGHT_LIMIT (RL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame          (frame),
        .go             (go),
        .btnL           (btnL),
        .btnR           (btnR),
        .road_h_address (road),
        .L              (L),
        .R              (R),
        .rollover       (rollover),
        .active         (active)
    );

    always #5 clk = ~clk;

    // Frame-level model; button decisions see the input sampled two edges back.
    task automatic model_edge(input logic f, input logic g, input logic bl,
                              input logic br, input logic [15:0] a,
                              input logic rs);
        bit sl, sr;
        bit lo, ro, wr;
        if (rs) begin
            m_mode = M_IDLE;
            m_frames = 0;
            hl.delete(); hr.delete();
            hl.push_back(1'b0); hl.push_back(1'b0);
            hr.push_back(1'b0); hr.push_back(1'b0);
            exp_v = 4'b0000;
            return;
        end
        sl = hl[hl.size()-2];
        sr = hr[hr.size()-2];
        hl.push_back(bl); hr.push_back(br);
        if (hl.size() > 4) begin
            void'(hl.pop_front());
            void'(hr.pop_front());
        end
        lo = 1'b0; ro = 1'b0; wr = 1'b0;
        if (m_mode == M_IDLE) begin
            m_frames = 0;
            if (g) m_mode = M_RUN;
        end else if (m_mode == M_W1) begin
            m_mode = M_W2;
        end else if (m_mode == M_W2) begin
            m_mode = M_RUN;
            m_frames = 0;
        end else if (f) begin
            m_frames = m_frames + 1;
            if (m_frames == STEP) begin
                m_frames = 0;
                if (sl && !sr) begin
                    if (int'(a) > int'(LL)) lo = 1'b1;
                    else wr = 1'b1;
                end else if (sr && !sl) begin
                    if (int'(a) < int'(RL)) ro = 1'b1;
                    else wr = 1'b1;
                end
                if (wr) m_mode = M_W1;
            end
        end
        exp_v = {lo, ro, wr, m_mode != M_IDLE};
    endtask

    task automatic cyc(input logic f, input logic g, input logic bl,
                       input logic br, input logic [15:0] a,
                       input logic rs);
        frame = f; go = g; btnL = bl; btnR = br; road = a; reset = rs;
        @(posedge clk);
        #1;
        model_edge(f, g, bl, br, a, rs);
    endtask

    task automatic test_reset;
        cyc(1, 1, 1, 1, 16'd300, 1);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: got LRoA=%b need 0000",
                     {L, R, rollover, active});
        end
        n_tests++;
        if ({L, R, rollover, active} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_model: got %b need %b",
                     {L, R, rollover, active}, exp_v);
        end
    endtask

    task automatic test_steer_right;
        int npulse;
        logic [3:0] want;
        npulse = 0;
        cyc(0, 1, 0, 1, 16'd300, 1);
        repeat (3) cyc(0, 1, 0, 1, 16'd300, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1, 0, 1, 16'd300, 0);
            want = (i == 2 || i == 4) ? 4'b0101 : 4'b0001;
            if (R) npulse++;
            n_tests++;
            if ({L, R, rollover, active} !== want ||
                exp_v !== want) begin
                n_fail++;
                $display("FAIL steer_r f%0d: got %b need %b model %b",
                         i, {L, R, rollover, active}, want, exp_v);
            end
            cyc(0, 1, 0, 1, 16'd300, 0);
            if (R) npulse++;
        end
        n_tests++;
        if (npulse !== 2) begin
            n_fail++;
            $display("FAIL steer_r_count: got %0d need 2", npulse);
        end
    endtask

    task automatic test_rollover_left;
        logic [3:0] want [4];
        want[0] = 4'b0011;
        want[1] = 4'b0001;
        want[2] = 4'b0001;
        want[3] = 4'b0001;
        cyc(0, 1, 1, 0, 16'd8, 1);
        repeat (3) cyc(0, 1, 1, 0, 16'd8, 0);
        cyc(1, 1, 1, 0, 16'd8, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 0, (i < 3) ? 16'd8 : 16'd9, 0);
            n_tests++;
            if ({L, R, rollover, active} !== want[i] ||
                exp_v !== want[i]) begin
                n_fail++;
                $display("FAIL wrap_l s%0d: got %b need %b model %b",
                         i, {L, R, rollover, active}, want[i], exp_v);
            end
        end
        cyc(1, 1, 1, 0, 16'd9, 0);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b1001) begin
            n_fail++;
            $display("FAIL wrap_resume: got %b need 1001",
                     {L, R, rollover, active});
        end
    endtask

    task automatic test_both_buttons;
        int bad;
        bad = 0;
        cyc(0, 1, 1, 1, 16'd300, 1);
        repeat (3) cyc(0, 1, 1, 1, 16'd300, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(i[0] ? 1'b0 : 1'b1, 1, 1, 1, 16'd300, 0);
            if ({L, R, rollover} !== 3'b000) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL both_btn: got %0d pulse cycles need 0", bad);
        end
    endtask

    task automatic test_idle_go;
        int bad;
        bad = 0;
        cyc(0, 0, 0, 1, 16'd300, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(i[0] ? 1'b0 : 1'b1, 0, 0, 1, 16'd300, 0);
            if ({L, R, rollover, active} !== 4'b0000) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_hold: got %0d busy cycles need 0", bad);
        end
        cyc(0, 1, 0, 1, 16'd300, 0);
        cyc(1, 0, 0, 1, 16'd300, 0);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0001) begin
            n_fail++;
            $display("FAIL go_first: got %b need 0001",
                     {L, R, rollover, active});
        end
        cyc(1, 0, 0, 1, 16'd300, 0);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0101) begin
            n_fail++;
            $display("FAIL go_r: got %b need 0101",
                     {L, R, rollover, active});
        end
    endtask

    task automatic test_reset_in_wrap;
        cyc(0, 1, 0, 1, 16'd560, 1);
        repeat (3) cyc(0, 1, 0, 1, 16'd560, 0);
        cyc(1, 1, 0, 1, 16'd560, 0);
        cyc(1, 1, 0, 1, 16'd560, 0);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0011) begin
            n_fail++;
            $display("FAIL wrap_r: got %b need 0011",
                     {L, R, rollover, active});
        end
        cyc(1, 1, 0, 1, 16'd560, 1);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrap_reset: got %b need 0000",
                     {L, R, rollover, active});
        end
        cyc(0, 0, 0, 1, 16'd560, 0);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrap_idle: got %b need 0000",
                     {L, R, rollover, active});
        end
    endtask

    task automatic test_sync_latency;
        cyc(0, 1, 0, 1, 16'd300, 1);
        repeat (3) cyc(0, 1, 0, 1, 16'd300, 0);
        cyc(1, 1, 0, 1, 16'd300, 0);
        cyc(0, 1, 0, 0, 16'd300, 0);
        cyc(1, 1, 0, 0, 16'd300, 0);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0101 || exp_v !== 4'b0101) begin
            n_fail++;
            $display("FAIL sync_old: got %b need 0101 model %b",
                     {L, R, rollover, active}, exp_v);
        end
        cyc(1, 1, 0, 0, 16'd300, 0);
        cyc(1, 1, 0, 0, 16'd300, 0);
        n_tests++;
        if ({L, R, rollover, active} !== 4'b0001) begin
            n_fail++;
            $display("FAIL sync_new: got %b need 0001",
                     {L, R, rollover, active});
        end
    endtask

    task automatic test_random;
        logic [15:0] addrs [8];
        logic [15:0] a;
        logic f, g, bl, br, rs;
        int bad, excl;
        addrs[0] = 16'd7;   addrs[1] = 16'd8;
        addrs[2] = 16'd9;   addrs[3] = 16'd300;
        addrs[4] = 16'd559; addrs[5] = 16'd560;
        addrs[6] = 16'd561; addrs[7] = 16'hFFFF;
        bad = 0;
        excl = 0;
        cyc(0, 0, 0, 0, 16'd300, 1);
        for (int i = 0; i < 600; i++) begin
            f  = ($urandom_range(0, 2) == 0);
            g  = ($urandom_range(0, 3) != 0);
            bl = $urandom_range(0, 1);
            br = $urandom_range(0, 1);
            rs = ($urandom_range(0, 79) == 0);
            a  = addrs[$urandom_range(0, 7)];
            cyc(f, g, bl, br, a, rs);
            if ({L, R, rollover, active} !== exp_v) begin
                bad++;
                if (bad < 5)
                    $display("FAIL rand c%0d: got %b need %b", i,
                             {L, R, rollover, active}, exp_v);
            end
            if (int'(L) + int'(R) + int'(rollover) > 1) excl++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rand_total: got %0d bad cycles need 0", bad);
        end
        n_tests++;
        if (excl !== 0) begin
            n_fail++;
            $display("FAIL rand_excl: got %0d overlap cycles need 0", excl);
        end
    endtask

    initial begin
        test_reset;
        test_steer_right;
        test_rollover_left;
        test_both_buttons;
        test_idle_go;
        test_reset_in_wrap;
        test_sync_latency;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/road_steer_ctrl.md
ROAD_STEER_CTRL -- requirements
Module: road_steer_ctrl

Interface
REQ-001 SHALL have parameter STEP_FRAMES, default 2, frames between steering decisions (legal 1..255).
REQ-002 SHALL have parameter LEFT_LIMIT, default 16'd8, lowest legal road_h_address.
REQ-003 SHALL have parameter RIGHT_LIMIT, default 16'd560, highest legal road_h_address.
REQ-004 SHALL have port clk, input, 1, system clock; the only clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port frame, input, 1, one-clk pulse per video frame.
REQ-007 SHALL have port go, input, 1, start-game request, level.
REQ-008 SHALL have port btnL, input, 1, left steer button, asynchronous.
REQ-009 SHALL have port btnR, input, 1, right steer button, asynchronous.
REQ-010 SHALL have port road_h_address, input, 16, current road position fed back from the road horizontal counter.
REQ-011 SHALL have port L, output, 1, one-clk pulse that moves the road counter down by one step (-2 px).
REQ-012 SHALL have port R, output, 1, one-clk pulse that moves the road counter up by one step (+2 px).
REQ-013 SHALL have port rollover, output, 1, one-clk pulse that makes the road counter load its reset position.
REQ-014 SHALL have port active, output, 1, high while in RUN or WRAP.

Function
REQ-015 SHALL pass btnL/btnR through a 2-flop synchronizer; decisions use synchronized values only (2-clk latency).
REQ-016 SHALL implement FSM states IDLE, RUN, WRAP1, WRAP2.
REQ-017 IDLE -> RUN on go=1; all outputs low in IDLE; frame count held at 0.
REQ-018 In RUN, an 8-bit frame counter SHALL increment on each frame pulse and wrap to 0 after STEP_FRAMES-1; the frame pulse causing the wrap is the decision frame.
REQ-019 On the decision frame, the combinational decision SHALL be registered, so L/R/rollover assert exactly 1 clk after the frame pulse.
REQ-020 Decision: btnL only and road_h_address > LEFT_LIMIT -> L; btnR only and road_h_address < RIGHT_LIMIT -> R.
REQ-021 Decision: btnL only and road_h_address <= LEFT_LIMIT, or btnR only and road_h_address >= RIGHT_LIMIT -> rollover, and go to WRAP1.
REQ-022 Decision: both buttons or neither -> no pulse.
REQ-023 L, R, rollover SHALL be mutually exclusive; at most one is high in any cycle.
REQ-024 WRAP1 lasts 1 clk with rollover high; WRAP2 lasts 1 clk with all pulses low (counter load settles); then -> RUN with frame counter cleared.
REQ-025 Frame pulses arriving during WRAP1/WRAP2 SHALL be ignored.
REQ-026 go dropping to 0 SHALL NOT leave RUN; only reset returns to IDLE.
REQ-027 Limit comparisons SHALL be 16-bit unsigned.

Reset
REQ-028 reset SHALL be sampled on posedge clk only, with priority over all other inputs.
REQ-029 After reset: state IDLE, frame counter 0, synchronizer flops 0, L=R=rollover=0, active=0.
REQ-030 reset asserted in WRAP1 SHALL drop rollover on the next edge; no pending pulse survives reset.

Structure
REQ-031 State encoding and default LEFT_LIMIT/RIGHT_LIMIT/STEP_FRAMES SHALL live in the shared road game package.
REQ-032 The synchronizer SHALL be a separate sub-module sync2 (1-bit, instantiated twice).
REQ-033 The design SHALL contain no latches and no combinational path from inputs to outputs.

Verification
REQ-034 reset, go=1, btnR=1, road_h_address=16'd300, STEP_FRAMES=2, 4 frame pulses -> exactly 2 R pulses, each 1 clk after the 2nd and 4th frame pulses.
REQ-035 btnL=1, road_h_address=16'd8, decision frame -> rollover for 1 clk, active=1, no L; next 2 frame pulses within WRAP ignored; RUN resumes.
REQ-036 btnL=btnR=1, road_h_address=16'd300, 6 frame pulses -> L=R=rollover=0 throughout.
REQ-037 go=0 for 10 frames with btnR=1 -> stays IDLE, no pulses; go=1 -> RUN, first R after STEP_FRAMES frames.
REQ-038 reset asserted in the clk rollover is high -> rollover=0 and state IDLE on the next edge.
REQ-039 btnR toggling 1 clk before a decision frame -> decision uses the pre-toggle value (2-clk synchronizer latency).
